// File: rtl/system_issue_unit.sv
// system_issue_unit
//   Issue stage in front of the SYSTEM execution unit. Decodes SYSTEM
//   instructions into t_sysop, buffers them in a 2-entry skid buffer so that
//   o_ready is a flop, and presents one op per cycle to execute/writeback.
//   SCALL, SBREAK and illegal encodings never reach execute; they park in the
//   output slot and raise a held trap request until the trap controller acks,
//   after which one FLUSH cycle discards everything buffered behind them.
//
// Ports
//   i_aclk, i_reset          clock, synchronous active-high reset
//   i_valid/o_ready          upstream handshake (o_ready is registered)
//   i_instr, i_pc            raw instruction word and its address
//   o_valid/i_ready          downstream handshake
//   o_op, o_rd, o_pc         decoded op, destination register, address
//   o_trap_req/o_trap_cause  trap request (0=SCALL, 1=SBREAK, 2=illegal)
//   i_trap_ack               trap controller accepted the request
//   o_dbg_state              FSM state (0=RUN, 1=TRAP, 2=FLUSH)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready of the same interface, and the
// payload is held stable while valid && !ready.

package system_issue_pkg;
  typedef enum logic [3:0] {
    SOP_SCALL      = 4'd0,
    SOP_SBREAK     = 4'd1,
    SOP_RDCYCLE    = 4'd2,
    SOP_RDCYCLEH   = 4'd3,
    SOP_RDTIME     = 4'd4,
    SOP_RDTIMEH    = 4'd5,
    SOP_RDINSTRET  = 4'd6,
    SOP_RDINSTRETH = 4'd7,
    SOP_ILLEGAL    = 4'd8
  } t_sysop;
endpackage

module system_issue_unit
  import system_issue_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                i_aclk,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_instr,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_valid,
  input  logic                i_ready,
  output t_sysop              o_op,
  output logic [4:0]          o_rd,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_trap_req,
  output logic [1:0]          o_trap_cause,
  input  logic                i_trap_ack,
  output logic [1:0]          o_dbg_state
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_TRAP  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  function automatic t_sysop decode(input logic [31:0] instr);
    t_sysop op;
    op = SOP_ILLEGAL;
    if (instr[6:0] == 7'b1110011) begin
      if (instr[14:12] == 3'b000) begin
        if (instr[19:15] == 5'd0 && instr[11:7] == 5'd0) begin
          if (instr[31:20] == 12'h000)      op = SOP_SCALL;
          else if (instr[31:20] == 12'h001) op = SOP_SBREAK;
        end
      end else if (instr[14:12] == 3'b010 && instr[19:15] == 5'd0) begin
        case (instr[31:20])
          12'hC00: op = SOP_RDCYCLE;
          12'hC80: op = SOP_RDCYCLEH;
          12'hC01: op = SOP_RDTIME;
          12'hC81: op = SOP_RDTIMEH;
          12'hC02: op = SOP_RDINSTRET;
          12'hC82: op = SOP_RDINSTRETH;
          default: op = SOP_ILLEGAL;
        endcase
      end
    end
    return op;
  endfunction

  function automatic logic is_trap(input t_sysop op);
    return (op == SOP_SCALL) || (op == SOP_SBREAK) || (op == SOP_ILLEGAL);
  endfunction

  logic [1:0]          state_q, state_d;
  logic                ready_q, ready_d;
  logic                slot_full_q, slot_full_d;
  t_sysop              slot_op_q, slot_op_d;
  logic [4:0]          slot_rd_q, slot_rd_d;
  logic [PC_WIDTH-1:0] slot_pc_q, slot_pc_d;
  logic [1:0]          cnt_q, cnt_d;
  t_sysop              e0_op_q, e0_op_d, e1_op_q, e1_op_d;
  logic [4:0]          e0_rd_q, e0_rd_d, e1_rd_q, e1_rd_d;
  logic [PC_WIDTH-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;

  t_sysop     in_op;
  logic       accept;
  logic       slot_free;
  logic       take_in;
  logic       pop;
  logic [1:0] cnt_after_pop;

  always_comb begin
    state_d     = state_q;
    slot_full_d = slot_full_q;
    slot_op_d   = slot_op_q;
    slot_rd_d   = slot_rd_q;
    slot_pc_d   = slot_pc_q;
    cnt_d       = cnt_q;
    e0_op_d     = e0_op_q;
    e0_rd_d     = e0_rd_q;
    e0_pc_d     = e0_pc_q;
    e1_op_d     = e1_op_q;
    e1_rd_d     = e1_rd_q;
    e1_pc_d     = e1_pc_q;
    take_in     = 1'b0;
    pop         = 1'b0;

    in_op  = decode(i_instr);
    accept = i_valid && ready_q;
    // In RUN a full slot always holds a non-trap op (trap ops move the FSM
    // to TRAP as they load), so it frees whenever downstream takes it.
    slot_free = (state_q == ST_RUN) && (!slot_full_q || i_ready);

    if (slot_free) begin
      if (cnt_q != 2'd0) begin
        // Older buffered ops go first to keep FIFO order.
        pop         = 1'b1;
        slot_full_d = 1'b1;
        slot_op_d   = e0_op_q;
        slot_rd_d   = e0_rd_q;
        slot_pc_d   = e0_pc_q;
      end else if (accept) begin
        // Empty buffer: bypass straight into the slot for 1-cycle latency.
        take_in     = 1'b1;
        slot_full_d = 1'b1;
        slot_op_d   = in_op;
        slot_rd_d   = i_instr[11:7];
        slot_pc_d   = i_pc;
      end else begin
        slot_full_d = 1'b0;
      end
      if (slot_full_d && is_trap(slot_op_d)) state_d = ST_TRAP;
    end

    cnt_after_pop = cnt_q;
    if (pop) begin
      e0_op_d       = e1_op_q;
      e0_rd_d       = e1_rd_q;
      e0_pc_d       = e1_pc_q;
      cnt_after_pop = cnt_q - 2'd1;
    end
    cnt_d = cnt_after_pop;
    if (accept && !take_in) begin
      if (cnt_after_pop == 2'd0) begin
        e0_op_d = in_op;
        e0_rd_d = i_instr[11:7];
        e0_pc_d = i_pc;
      end else begin
        e1_op_d = in_op;
        e1_rd_d = i_instr[11:7];
        e1_pc_d = i_pc;
      end
      cnt_d = cnt_after_pop + 2'd1;
    end

    case (state_q)
      ST_TRAP: begin
        if (i_trap_ack) begin
          state_d     = ST_FLUSH;
          slot_full_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        // Everything accepted behind the trapping op is dropped.
        state_d = ST_RUN;
        cnt_d   = 2'd0;
      end
      default: ;
    endcase

    ready_d = (cnt_d != 2'd2) && (state_d != ST_FLUSH);
  end

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      ready_q     <= 1'b1;
      slot_full_q <= 1'b0;
      slot_op_q   <= SOP_SCALL;
      slot_rd_q   <= '0;
      slot_pc_q   <= '0;
      cnt_q       <= '0;
      e0_op_q     <= SOP_SCALL;
      e0_rd_q     <= '0;
      e0_pc_q     <= '0;
      e1_op_q     <= SOP_SCALL;
      e1_rd_q     <= '0;
      e1_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      slot_full_q <= slot_full_d;
      slot_op_q   <= slot_op_d;
      slot_rd_q   <= slot_rd_d;
      slot_pc_q   <= slot_pc_d;
      cnt_q       <= cnt_d;
      e0_op_q     <= e0_op_d;
      e0_rd_q     <= e0_rd_d;
      e0_pc_q     <= e0_pc_d;
      e1_op_q     <= e1_op_d;
      e1_rd_q     <= e1_rd_d;
      e1_pc_q     <= e1_pc_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = slot_full_q && (state_q == ST_RUN);
  assign o_op         = slot_op_q;
  assign o_rd         = slot_rd_q;
  assign o_pc         = slot_pc_q;
  assign o_trap_req   = (state_q == ST_TRAP);
  // The slot is frozen in TRAP, so the cause is stable for the whole request.
  assign o_trap_cause = (state_q != ST_TRAP)       ? 2'd0 :
                        (slot_op_q == SOP_SCALL)   ? 2'd0 :
                        (slot_op_q == SOP_SBREAK)  ? 2'd1 : 2'd2;
  assign o_dbg_state  = state_q;

endmodule
